// File: rtl/fifo_rr_enq_arbiter.sv
// Round-robin arbiter sharing one FIFO enqueue port among NREQ requesters.
// Grants bursts of up to BURST words; fifo_full back-pressures the owner combinationally.
module fifo_rr_enq_arbiter #(
  parameter  int NREQ  = 4,
  parameter  int DW    = 32,
  parameter  int BURST = 4,
  localparam int OW    = $clog2(NREQ),
  localparam int CW    = $clog2(BURST) + 1
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   din,
  output logic [NREQ-1:0]      gnt,
  input  logic                 fifo_full,
  output logic                 fifo_enq,
  output logic [DW-1:0]        fifo_din,
  output logic [OW-1:0]        owner,
  output logic                 busy
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t                  state, state_n;
  logic [OW-1:0]           owner_n, last, last_n, pick, idx;
  logic [CW-1:0]           cnt, cnt_n;
  logic                    accept, any_req;
  logic [NREQ-1:0][DW-1:0] din_v;

  assign din_v    = din;
  assign accept   = (state == HOLD) && req[owner] && !fifo_full;
  assign fifo_enq = accept;
  assign fifo_din = din_v[owner];
  assign busy     = (state == HOLD);
  assign any_req  = |req;

  for (genvar i = 0; i < NREQ; i++) begin : g_gnt
    assign gnt[i] = accept && (owner == OW'(i));
  end

  // Walk from farthest to nearest so the requester closest after 'last' wins.
  always_comb begin
    pick = last;
    idx  = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = OW'((int'(last) + k) % NREQ);
      if (req[idx]) pick = idx;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    last_n  = last;
    cnt_n   = cnt;
    case (state)
      IDLE: if (any_req) begin
        owner_n = pick;
        cnt_n   = '0;
        state_n = HOLD;
      end
      HOLD: begin
        if ((accept && cnt == CW'(BURST - 1)) || !req[owner]) begin
          last_n  = owner;
          cnt_n   = '0;
          state_n = IDLE;
        end else if (accept) begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= IDLE;
      owner <= '0;
      last  <= OW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      last  <= last_n;
      cnt   <= cnt_n;
    end
  end

endmodule

// File: tb/tb_fifo_rr_enq_arbiter.sv
// Bench for fifo_rr_enq_arbiter: directed scenarios plus random traffic against a
// word-level reference model; each requester emits an ordered word stream.
module tb_fifo_rr_enq_arbiter;
  localparam int NREQ = 4, DW = 32, BURST = 4, OW = 2;
  localparam int VW = NREQ + DW + OW + 2;

  logic                 CLK = 1'b0, RST;
  logic [NREQ-1:0]      req, gnt;
  logic [NREQ*DW-1:0]   din;
  logic                 fifo_full, fifo_enq, busy;
  logic [DW-1:0]        fifo_din;
  logic [OW-1:0]        owner;

  fifo_rr_enq_arbiter #(.NREQ(NREQ), .DW(DW), .BURST(BURST)) dut (
    .CLK(CLK), .RST(RST), .req(req), .din(din), .gnt(gnt), .fifo_full(fifo_full),
    .fifo_enq(fifo_enq), .fifo_din(fifo_din), .owner(owner), .busy(busy));

  always #5 CLK = ~CLK;

  int checks = 0, errors = 0;
  int seq [NREQ];          // words consumed so far per requester
  bit m_busy;              // model: a grant is being held
  int m_owner, m_last, m_beats;

  function automatic logic [DW-1:0] word(int i, int s);
    return DW'(i * (1 << 24) + s);
  endfunction

  task automatic set_din();
    for (int i = 0; i < NREQ; i++) din[i*DW +: DW] = word(i, seq[i]);
  endtask

  function automatic bit m_acc();
    return m_busy && req[m_owner] && !fifo_full;
  endfunction

  function automatic logic [VW-1:0] expv();
    logic [NREQ-1:0] g;
    g = m_acc() ? NREQ'(1 << m_owner) : NREQ'(0);
    return {g, m_acc(), word(m_owner, seq[m_owner]), m_busy, OW'(m_owner)};
  endfunction

  function automatic logic [VW-1:0] actv();
    return {gnt, fifo_enq, fifo_din, busy, owner};
  endfunction

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_last = NREQ - 1; m_beats = 0;
  endtask

  // One clock edge: advance the word-level model, then refresh producer data.
  task automatic cyc();
    bit acc;
    int o;
    @(posedge CLK);
    acc = m_acc();
    o = m_last;
    if (!m_busy) begin
      if (req != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          o = (m_last + k) % NREQ;
          if (req[o]) break;
        end
        m_owner = o; m_busy = 1; m_beats = 0;
      end
    end else if (acc) begin
      seq[m_owner]++;
      m_beats++;
      if (m_beats == BURST) begin m_last = m_owner; m_busy = 0; end
    end else if (!req[m_owner]) begin
      m_last = m_owner; m_busy = 0;
    end
    #1;
    set_din();
  endtask

  task automatic do_reset();
    RST = 1'b1;
    model_reset();
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1; req = '1; fifo_full = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({gnt, fifo_enq, busy, owner, fifo_din} !== {4'b0000, 1'b0, 1'b0, 2'd0, word(0, seq[0])}) begin
      errors++;
      $display("FAIL reset_outputs: gnt=%b enq=%b busy=%b owner=%0d din=%h", gnt, fifo_enq, busy, owner, fifo_din);
    end
    @(posedge CLK); #1; RST = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL reset_first_idle: busy=%b gnt=%b want busy=0 gnt=0000", busy, gnt);
    end
    cyc();
    #1;
    checks++;
    if ({gnt, fifo_enq, busy, fifo_din} !== {4'b0001, 1'b1, 1'b1, word(0, seq[0])}) begin
      errors++; $display("FAIL reset_first_word: gnt=%b enq=%b busy=%b want 0001/1/1", gnt, fifo_enq, busy);
    end
  endtask

  task automatic test_single();
    int base, cycles;
    logic [12:0] pat;
    do_reset();
    base = seq[1]; cycles = 0; pat = '0;
    req = 4'b0010; fifo_full = 1'b0;
    for (int c = 0; c < 40 && (seq[1] - base) < 10; c++) begin
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL single_model: got %h want %h", actv(), expv()); end
      if (busy && owner !== 2'd1) begin errors++; $display("FAIL single_owner: got %0d want 1", owner); end
      pat = {pat[11:0], fifo_enq};
      cyc();
      cycles++;
    end
    req = '0;
    checks++;
    if (cycles != 13 || pat !== 13'b0_1111_0_1111_0_11) begin
      errors++; $display("FAIL single_pattern: cycles=%0d pat=%b want 13 / 0111101111011", cycles, pat);
    end
  endtask

  task automatic test_all_req();
    int nacc;
    do_reset();
    req = '1; fifo_full = 1'b0; nacc = 0;
    for (int c = 0; c < 25; c++) begin
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL allreq_model: got %h want %h", actv(), expv()); end
      if (!$onehot0(gnt)) begin errors++; $display("FAIL allreq_onehot: gnt=%b", gnt); end
      if (fifo_enq) begin
        if (int'(owner) != (nacc / BURST) % NREQ) begin
          errors++; $display("FAIL allreq_rotation: owner=%0d want %0d", owner, (nacc / BURST) % NREQ);
        end
        nacc++;
      end
      cyc();
    end
    checks++;
    if (nacc != 20) begin errors++; $display("FAIL allreq_beats: got %0d want 20", nacc); end
  endtask

  task automatic test_full();
    bit exp_enq, exp_busy;
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 9; c++) begin
      fifo_full = (c >= 3 && c <= 5);
      exp_enq  = (c == 1 || c == 2 || c == 6 || c == 7);
      exp_busy = (c != 0 && c != 8);
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL full_model: got %h want %h", actv(), expv()); end
      if (fifo_enq !== exp_enq || busy !== exp_busy || gnt !== (exp_enq ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL full_cycle%0d: enq=%b busy=%b gnt=%b want %b/%b", c, fifo_enq, busy, gnt, exp_enq, exp_busy);
      end
      cyc();
    end
    fifo_full = 1'b0; req = '0;
  endtask

  task automatic test_drop();
    int acc0;
    do_reset();
    fifo_full = 1'b0; acc0 = 0;
    for (int c = 0; c < 9; c++) begin
      req = {2'b01, 1'b0, (c < 3)};
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL drop_model: got %h want %h", actv(), expv()); end
      if (gnt[0]) acc0++;
      if (c == 4 && busy !== 1'b0) begin errors++; $display("FAIL drop_idle: busy=%b want 0", busy); end
      if (c == 5 && (owner !== 2'd2 || gnt !== 4'b0100)) begin
        errors++; $display("FAIL drop_next_owner: owner=%0d gnt=%b want 2/0100", owner, gnt);
      end
      cyc();
    end
    req = '0;
    checks++;
    if (acc0 != 2) begin errors++; $display("FAIL drop_accepts: got %0d want 2", acc0); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req = '1; fifo_full = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL rstmid_model: got %h want %h", actv(), expv()); end
      cyc();
    end
    #1;
    checks++;
    if (gnt !== 4'b0001) begin errors++; $display("FAIL rstmid_pre: gnt=%b want 0001", gnt); end
    #2; RST = 1'b1; #1;
    checks++;
    if (gnt !== 4'b0000 || fifo_enq !== 1'b0 || busy !== 1'b0 || owner !== 2'd0) begin
      errors++; $display("FAIL rstmid_async: gnt=%b enq=%b busy=%b owner=%0d want 0000/0/0/0", gnt, fifo_enq, busy, owner);
    end
    model_reset();
    @(posedge CLK); #1; RST = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL rstmid_post_model: got %h want %h", actv(), expv()); end
      if (c == 1 && (owner !== 2'd0 || gnt !== 4'b0001)) begin
        errors++; $display("FAIL rstmid_restart: owner=%0d gnt=%b want 0/0001", owner, gnt);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      req = NREQ'($urandom);
      fifo_full = ($urandom_range(0, 3) == 0);
      #1;
      checks++;
      if (actv() !== expv()) begin errors++; $display("FAIL random_c%0d: got %h want %h", c, actv(), expv()); end
      cyc();
    end
    req = '0; fifo_full = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) seq[i] = 0;
    set_din();
    test_reset();
    test_single();
    test_all_req();
    test_full();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
